fb_painter: RTL and testbench
=============================

// Module: fb_painter
// PURPOSE
//  Double-buffered 64x64 RGB888 framebuffer with PWM colour slicing. Sits directly
//  upstream of led_driver, replacing a procedural painter: one instance per half-panel
//  (y0 / y1). A host writer fills the back bank via valid/ready; swaps occur only on
//  frame boundaries so the panel never shows a torn image.
// PARAMETERS
//  XW   6   column address width (panel width = 2**XW)
//  YW   6   row address width (panel height = 2**YW)
//  CW   8   bits per colour channel; also width of subframe
//  FW   13  frame counter width
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high
//  frame      in   FW     frame counter from led_driver
//  subframe   in   CW     PWM slice index from led_driver
//  x          in   XW     read column
//  y          in   YW     read row
//  rgb        out  3      {R,G,B} on/off for (x,y) at subframe
//  wr_valid   in   1      write request
//  wr_ready   out  1      write accepted when valid&ready
//  wr_x       in   XW     write column
//  wr_y       in   YW     write row
//  wr_data    in   3*CW   {R[CW],G[CW],B[CW]}
//  swap_req   in   1      1-clk pulse: publish back bank at next frame boundary
//  swap_done  out  1      1-clk pulse when swap taken
// BEHAVIOUR
//  Reset: rgb=0, wr_ready=0, swap_done=0, front=0, pending=0, frame_q=0.
//   RAM contents undefined/untouched. wr_ready rises the cycle after reset deasserts.
//  Read: addr={front,y,x}; sync RAM read; subframe registered alongside.
//   rgb valid exactly 1 clk after x/y/subframe presented (registered RAM output, combinational
//   compare). Channel bit = (chan > subframe_q), unsigned CW-bit compare:
//   chan=0 -> always off; chan=255 -> on for subframes 0..254, off at 255.
//  Write: accepted cycle (wr_valid & wr_ready) writes {~front,wr_y,wr_x}<=wr_data.
//   No buffering; wr_x/wr_y/wr_data must be held while valid & !ready.
//   Write and read never hit the same bank, so no RAM collision.
//  Swap FSM states: IDLE, PENDING.
//   IDLE: swap_req -> PENDING (wr_ready=0 in PENDING: back bank frozen).
//   Boundary = (frame != frame_q); frame_q <= frame every cycle.
//   PENDING & boundary -> front<=~front, swap_done=1 for one clk, -> IDLE, wr_ready=1 next clk.
//   swap_req coincident with boundary in IDLE -> swap taken that same cycle (no wait).
//   swap_req while PENDING: ignored (single swap).
//   Frame counter wrap (all-ones -> 0) counts as a boundary.
//   Reads at the boundary cycle use the old front; new front applies from the next clk.
//  Reset mid-swap: returns to IDLE, front=0, no swap_done.
// STRUCTURE
//  led_pkg: PANEL_XW, PANEL_YW, CW, FW constants; swap FSM state enum; rgb bit order.
//  One sub-module: fb_dpram (simple dual-port, 1 write / 1 sync-read port,
//   depth 2**(1+YW+XW), width 3*CW; infers ECP5 EBR). Swap FSM + compare stay local.
// TESTING
//  1 Reset: hold reset 3 clk -> rgb=0, wr_ready=0, swap_done=0; 1 clk after release wr_ready=1.
//  2 Write (3,5)=FF_80_00, swap_req, step frame; read (3,5): subframe 0x7F -> rgb=3'b110,
//    subframe 0x80 -> 3'b100, subframe 0xFF -> 3'b000; each appears 1 clk after x/y set.
//  3 Before swap, write (0,0)=FFFFFF to back; reading front (0,0) keeps old value until
//    frame increments; swap_done pulses exactly once on that cycle.
//  4 swap_req then wr_valid held -> wr_ready=0 until boundary; write lands in new back bank
//    (old front), not the displayed one.
//  5 swap_req on same clk as frame 0x1FFF->0x0000 -> swap_done that clk; second swap_req
//    while pending produces no extra swap_done.
//  6 Assert reset while PENDING -> no swap_done, front=0, reads return bank-0 data.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED panel pipeline (panel geometry, colour depth,
// frame counter width, swap FSM encoding, rgb bit order).
package led_pkg;

    localparam int PANEL_XW = 6;
    localparam int PANEL_YW = 6;
    localparam int PANEL_CW = 8;
    localparam int PANEL_FW = 13;

    // rgb output bit positions: {R,G,B}
    localparam int RGB_R = 2;
    localparam int RGB_G = 1;
    localparam int RGB_B = 0;

    typedef enum logic {
        SW_IDLE    = 1'b0,
        SW_PENDING = 1'b1
    } swap_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no output reset.
// Kept to the plain inference template so it maps onto block RAM.
module fb_dpram #(
    parameter int AW = 13,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_painter.sv
// Double-buffered framebuffer with PWM slicing; rgb 1 clk after x/y/subframe.
// Writes stall (wr_ready=0) while a swap waits for the next frame boundary.
module fb_painter
    import led_pkg::*;
#(
    parameter int XW = PANEL_XW,
    parameter int YW = PANEL_YW,
    parameter int CW = PANEL_CW,
    parameter int FW = PANEL_FW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FW-1:0]   frame,
    input  logic [CW-1:0]   subframe,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    output logic [2:0]      rgb,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [XW-1:0]   wr_x,
    input  logic [YW-1:0]   wr_y,
    input  logic [3*CW-1:0] wr_data,
    input  logic            swap_req,
    output logic            swap_done
);

    localparam int AW = 1 + YW + XW;

    swap_state_t   state, state_n;
    logic          front;
    logic [FW-1:0] frame_q;
    logic [CW-1:0] subframe_q;
    logic          rd_vld;
    logic          boundary;
    logic          swap_take;
    logic [3*CW-1:0] rd_data;

    assign boundary = (frame != frame_q);

    always_comb begin
        state_n   = state;
        swap_take = 1'b0;
        case (state)
            SW_IDLE: begin
                if (swap_req) begin
                    // A request landing on a boundary is served at once.
                    if (boundary) begin
                        swap_take = 1'b1;
                    end else begin
                        state_n = SW_PENDING;
                    end
                end
            end
            SW_PENDING: begin
                if (boundary) begin
                    swap_take = 1'b1;
                    state_n   = SW_IDLE;
                end
            end
            default: state_n = SW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SW_IDLE;
            front      <= 1'b0;
            frame_q    <= '0;
            subframe_q <= '0;
            wr_ready   <= 1'b0;
            rd_vld     <= 1'b0;
        end else begin
            state      <= state_n;
            front      <= front ^ swap_take;
            frame_q    <= frame;
            subframe_q <= subframe;
            wr_ready   <= (state_n == SW_IDLE);
            rd_vld     <= 1'b1;
        end
    end

    assign swap_done = swap_take & ~reset;

    fb_dpram #(
        .AW (AW),
        .DW (3 * CW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_valid & wr_ready),
        .waddr ({~front, wr_y, wr_x}),
        .wdata (wr_data),
        .raddr ({front, y, x}),
        .rdata (rd_data)
    );

    // RAM output has no reset, so rgb is forced off until the first real read.
    always_comb begin
        rgb = 3'b000;
        if (rd_vld) begin
            rgb[RGB_R] = rd_data[3*CW-1:2*CW] > subframe_q;
            rgb[RGB_G] = rd_data[2*CW-1:CW]   > subframe_q;
            rgb[RGB_B] = rd_data[CW-1:0]      > subframe_q;
        end
    end

endmodule

// File: tb/tb_fb_painter.sv
// Directed bench for fb_painter: reset, PWM slicing, frame-aligned swaps, write stall, wrap, reset mid-swap.
module tb_fb_painter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x, y;
    logic [2:0]  rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_x, wr_y;
    logic [23:0] wr_data;
    logic        swap_req;
    logic        swap_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_painter dut (
        .clk       (clk),
        .reset     (reset),
        .frame     (frame),
        .subframe  (subframe),
        .x         (x),
        .y         (y),
        .rgb       (rgb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_done (swap_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int wx, input int wy, input logic [23:0] d);
        int n;
        wr_x     = 6'(wx);
        wr_y     = 6'(wy);
        wr_data  = d;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!wr_ready) chk("wr_timeout", 0, 1);
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int rx, input int ry, input logic [7:0] sf,
                      input logic [2:0] exp, input string tag);
        x        = 6'(rx);
        y        = 6'(ry);
        subframe = sf;
        cyc();
        chk(tag, rgb, exp);
    endtask

    initial begin
        reset = 1'b1; frame = '0; subframe = '0; x = '0; y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; swap_req = 1'b0;

        // 1: reset
        cyc(); cyc(); cyc();
        chk("rst_rgb", rgb, 0);
        chk("rst_rdy", wr_ready, 0);
        chk("rst_done", swap_done, 0);
        reset = 1'b0;
        chk("rdy_before_edge", wr_ready, 0);
        cyc();
        chk("rdy_after_rst", wr_ready, 1);

        // 2: fill bank 1, swap, PWM slices
        do_write(3, 5, 24'hFF8000);
        do_write(0, 0, 24'h000000);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("t2_rdy_pend", wr_ready, 0);
        frame = 13'd1;
        #4 chk("t2_done", swap_done, 1);
        cyc();
        chk("t2_done_end", swap_done, 0);
        chk("t2_rdy_back", wr_ready, 1);
        rd(3, 5, 8'h7F, 3'b110, "t2_sf7f");
        rd(3, 5, 8'h80, 3'b100, "t2_sf80");
        rd(3, 5, 8'hFF, 3'b000, "t2_sfff");
        rd(3, 5, 8'h00, 3'b110, "t2_sf00");

        // 3: back-bank write invisible until boundary (front=1, back=0)
        do_write(0, 0, 24'hFFFFFF);
        rd(0, 0, 8'h00, 3'b000, "t3_old_a");
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        rd(0, 0, 8'h00, 3'b000, "t3_old_b");
        chk("t3_no_done", swap_done, 0);
        frame = 13'd2;
        #4 chk("t3_done", swap_done, 1);
        cyc();
        chk("t3_bnd_read_old", rgb, 3'b000);
        cyc();
        chk("t3_new_front", rgb, 3'b111);
        chk("t3_once", swap_done, 0);

        // 4: write held across pending swap lands in old front (front=0 -> 1)
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("t4_rdy_pend", wr_ready, 0);
        wr_x = 6'd3; wr_y = 6'd5; wr_data = 24'h0000FF; wr_valid = 1'b1;
        cyc(); cyc(); cyc();
        chk("t4_rdy_held", wr_ready, 0);
        frame = 13'd3;
        #4 chk("t4_done", swap_done, 1);
        cyc();
        chk("t4_rdy_after", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        rd(3, 5, 8'h7F, 3'b110, "t4_disp_intact");
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        frame = 13'd4;
        #4 chk("t4_done2", swap_done, 1);
        cyc();
        rd(3, 5, 8'h00, 3'b001, "t4_landed");

        // 5: frame wrap as boundary; repeat request while pending (front=0)
        frame = 13'h1FFF;
        #4 chk("t5_bnd_no_req", swap_done, 0);
        cyc();
        frame = 13'h0000;
        swap_req = 1'b1;
        #4 chk("t5_wrap_done", swap_done, 1);
        cyc();
        swap_req = 1'b0;
        rd(3, 5, 8'h80, 3'b100, "t5_front1");
        swap_req = 1'b1;
        cyc();
        chk("t5_pend_rdy", wr_ready, 0);
        #4 chk("t5_req2_none", swap_done, 0);
        cyc();
        swap_req = 1'b0;
        frame = 13'd1;
        #4 chk("t5_done", swap_done, 1);
        cyc();
        frame = 13'd2;
        #4 chk("t5_no_extra", swap_done, 0);
        cyc();
        rd(3, 5, 8'h00, 3'b001, "t5_front0");

        // 6: reset while pending (front=1 first)
        swap_req = 1'b1;
        frame = 13'd3;
        #4 chk("t6_done", swap_done, 1);
        cyc();
        swap_req = 1'b0;
        rd(3, 5, 8'h00, 3'b110, "t6_front1");
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        reset = 1'b1;
        frame = 13'd4;
        #4 chk("t6_rst_no_done", swap_done, 0);
        cyc();
        cyc();
        chk("t6_rst_rgb", rgb, 0);
        chk("t6_rst_rdy", wr_ready, 0);
        reset = 1'b0;
        #4 chk("t6_post_no_done", swap_done, 0);
        cyc();
        chk("t6_rdy", wr_ready, 1);
        rd(3, 5, 8'h00, 3'b001, "t6_bank0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
